// File: rtl/dmem_pkg.sv
// Shared types and default geometry for the byte-enabled data memory and its dump engine.
// The dump engine is built only when DMEM_DUMP_EN is defined.
package dmem_pkg;

   localparam int unsigned DMEM_DEFAULT_DEPTH  = 129600;
   localparam int unsigned DMEM_DEFAULT_DATA_W = 32;

   typedef enum logic [1:0] {
      D_IDLE = 2'd0,
      D_READ = 2'd1,
      D_SEND = 2'd2,
      D_DONE = 2'd3
   } dump_state_t;

endpackage

// File: rtl/dmem_dump_ctrl.sv
// Full-memory dump sequencer: walks every word through a dedicated read port and
// streams it out over valid/ready. Instantiated by dmem_ram_p only under DMEM_DUMP_EN.
module dmem_dump_ctrl
   import dmem_pkg::*;
#(
   parameter int unsigned DATA_W = DMEM_DEFAULT_DATA_W,
   parameter int unsigned DEPTH  = DMEM_DEFAULT_DEPTH
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       dump_start,
   input  logic                       dump_ready,
   input  logic [DATA_W-1:0]          rd_data,
   output logic [$clog2(DEPTH)-1:0]   rd_idx,
   output logic                       dump_valid,
   output logic [$clog2(DEPTH)-1:0]   dump_addr,
   output logic [DATA_W-1:0]          dump_data,
   output logic                       dump_busy,
   output logic                       dump_done
);

   localparam int unsigned IDX_W = $clog2(DEPTH);

   dump_state_t       state_q, state_d;
   logic [IDX_W-1:0]  ptr_q, ptr_d;
   logic [IDX_W-1:0]  addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   // Next-state and registered-output decode; status flags follow the next state
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      addr_d  = addr_q;
      data_d  = data_q;
      unique case (state_q)
         D_IDLE: begin
            if (dump_start) begin
               state_d = D_READ;
               ptr_d   = '0;
            end
         end
         D_READ: begin
            addr_d  = ptr_q;
            data_d  = rd_data;
            state_d = D_SEND;
         end
         D_SEND: begin
            if (dump_ready) begin
               if (ptr_q == IDX_W'(DEPTH - 1)) begin
                  state_d = D_DONE;
               end else begin
                  ptr_d   = ptr_q + IDX_W'(1);
                  state_d = D_READ;
               end
            end
         end
         D_DONE: begin
            state_d = D_IDLE;
         end
         default: begin
            state_d = D_IDLE;
         end
      endcase
      valid_d = (state_d == D_SEND);
      busy_d  = (state_d != D_IDLE);
      done_d  = (state_d == D_DONE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= D_IDLE;
         ptr_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign rd_idx     = ptr_q;
   assign dump_valid = valid_q;
   assign dump_addr  = addr_q;
   assign dump_data  = data_q;
   assign dump_busy  = busy_q;
   assign dump_done  = done_q;

endmodule

// File: rtl/dmem_ram_p.sv
// Parametrised byte-enabled data memory with registered read, write-first forwarding and
// out-of-range flag. DMEM_DUMP_EN adds a second read port driving the dump engine.
module dmem_ram_p
   import dmem_pkg::*;
#(
   parameter int unsigned DATA_W    = DMEM_DEFAULT_DATA_W,
   parameter int unsigned DEPTH     = DMEM_DEFAULT_DEPTH,
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       we,
   input  logic [DATA_W/8-1:0]        be,
   input  logic                       re,
   input  logic [ADDR_W-1:0]          address,
   input  logic [DATA_W-1:0]          wd,
   output logic [DATA_W-1:0]          rd,
   output logic                       rd_valid,
   output logic                       oor,
   input  logic                       dump_start,
   input  logic                       dump_ready,
   output logic                       dump_valid,
   output logic [$clog2(DEPTH)-1:0]   dump_addr,
   output logic [DATA_W-1:0]          dump_data,
   output logic                       dump_busy,
   output logic                       dump_done
);

   localparam int unsigned NB    = DATA_W / 8;
   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned AX_W  = ADDR_W + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [AX_W-1:0]   addr_x_c;
   logic [AX_W-1:0]   idx_x_c;
   logic              in_range_c;
   logic [IDX_W-1:0]  idx_c;
   logic              range_unused_c;

   logic [DATA_W-1:0] rd_q, rd_d;
   logic              rd_valid_q, rd_valid_d;
   logic              oor_q, oor_d;

   // Range check one bit wider than the address so subtraction cannot wrap
   always_comb begin
      addr_x_c   = {1'b0, address};
      idx_x_c    = addr_x_c - AX_W'(BASE_ADDR);
      in_range_c = (addr_x_c >= AX_W'(BASE_ADDR)) && (idx_x_c < AX_W'(DEPTH));
      idx_c      = idx_x_c[IDX_W-1:0];
   end

   assign range_unused_c = ^idx_x_c[AX_W-1:IDX_W];

   always_ff @(posedge clk) begin
      for (int i = 0; i < NB; i++) begin
         if (we && in_range_c && be[i]) begin
            mem_q[idx_c][8*i +: 8] <= wd[8*i +: 8];
         end
      end
   end

   // CPU read port: enabled write lanes forward wd, the rest return stored bytes
   always_comb begin
      rd_d       = rd_q;
      rd_valid_d = re;
      oor_d      = (we || re) && !in_range_c;
      if (re) begin
         if (in_range_c) begin
            for (int i = 0; i < NB; i++) begin
               rd_d[8*i +: 8] = (we && be[i]) ? wd[8*i +: 8] : mem_q[idx_c][8*i +: 8];
            end
         end else begin
            rd_d = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_q       <= '0;
         rd_valid_q <= 1'b0;
         oor_q      <= 1'b0;
      end else begin
         rd_q       <= rd_d;
         rd_valid_q <= rd_valid_d;
         oor_q      <= oor_d;
      end
   end

   assign rd       = rd_q;
   assign rd_valid = rd_valid_q;
   assign oor      = oor_q;

`ifdef DMEM_DUMP_EN
   logic [IDX_W-1:0]  dump_idx_c;
   logic [DATA_W-1:0] dump_rdata_c;

   // Second read port sees pre-edge contents, so a same-cycle CPU write is not observed
   assign dump_rdata_c = mem_q[dump_idx_c];

   dmem_dump_ctrl #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_dump_ctrl (
      .clk        (clk),
      .reset      (reset),
      .dump_start (dump_start),
      .dump_ready (dump_ready),
      .rd_data    (dump_rdata_c),
      .rd_idx     (dump_idx_c),
      .dump_valid (dump_valid),
      .dump_addr  (dump_addr),
      .dump_data  (dump_data),
      .dump_busy  (dump_busy),
      .dump_done  (dump_done)
   );
`else
   logic dump_unused_c;

   assign dump_unused_c = dump_start ^ dump_ready;
   assign dump_valid    = 1'b0;
   assign dump_addr     = '0;
   assign dump_data     = '0;
   assign dump_busy     = 1'b0;
   assign dump_done     = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_ram_p.sv
// Bench for dmem_ram_p: three geometries share CPU stimulus and are checked against a
// byte-level memory model every cycle; dump checks depend on DMEM_DUMP_EN.
module tb_dmem_ram_p;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        we = 1'b0, re = 1'b0;
   logic [3:0]  be = 4'h0;
   logic [31:0] address = 32'h0, wd = 32'h0;
   logic        ds_c = 1'b0, dr_c = 1'b0, zero = 1'b0;

   logic [31:0] rd_a, rd_b, rd_c;
   logic        rv_a, rv_b, rv_c, oor_a, oor_b, oor_c;
   logic        dv_a, dv_b, dv_c, db_a, db_b, db_c, dn_a, dn_b, dn_c;
   logic [16:0] da_a;
   logic [3:0]  da_b;
   logic [2:0]  da_c;
   logic [31:0] dd_a, dd_b, dd_c;

   always #5 clk = ~clk;

   dmem_ram_p #(.DATA_W(32), .DEPTH(129600), .ADDR_W(32), .BASE_ADDR(0)) u_a (
      .clk(clk), .reset(reset), .we(we), .be(be), .re(re), .address(address), .wd(wd),
      .rd(rd_a), .rd_valid(rv_a), .oor(oor_a), .dump_start(zero), .dump_ready(zero),
      .dump_valid(dv_a), .dump_addr(da_a), .dump_data(dd_a), .dump_busy(db_a), .dump_done(dn_a));

   dmem_ram_p #(.DATA_W(32), .DEPTH(16), .ADDR_W(32), .BASE_ADDR(1000)) u_b (
      .clk(clk), .reset(reset), .we(we), .be(be), .re(re), .address(address), .wd(wd),
      .rd(rd_b), .rd_valid(rv_b), .oor(oor_b), .dump_start(zero), .dump_ready(zero),
      .dump_valid(dv_b), .dump_addr(da_b), .dump_data(dd_b), .dump_busy(db_b), .dump_done(dn_b));

   dmem_ram_p #(.DATA_W(32), .DEPTH(8), .ADDR_W(32), .BASE_ADDR(0)) u_c (
      .clk(clk), .reset(reset), .we(we), .be(be), .re(re), .address(address), .wd(wd),
      .rd(rd_c), .rd_valid(rv_c), .oor(oor_c), .dump_start(ds_c), .dump_ready(dr_c),
      .dump_valid(dv_c), .dump_addr(da_c), .dump_data(dd_c), .dump_busy(db_c), .dump_done(dn_c));

   logic [31:0] act_rd [3];
   logic        act_rv [3];
   logic        act_oor [3];
   assign act_rd[0] = rd_a;  assign act_rd[1] = rd_b;  assign act_rd[2] = rd_c;
   assign act_rv[0] = rv_a;  assign act_rv[1] = rv_b;  assign act_rv[2] = rv_c;
   assign act_oor[0] = oor_a; assign act_oor[1] = oor_b; assign act_oor[2] = oor_c;

   longint      base_k [3] = '{0, 1000, 0};
   longint      depth_k [3] = '{129600, 16, 8};
   logic [31:0] mdat [longint];
   logic [3:0]  mkn [longint];
   logic [31:0] exp_rd [3];
   logic [3:0]  exp_m [3];
   logic        exp_rv [3];
   logic        exp_oor [3];

   int total = 0;
   int bad = 0;
   bit chk_en = 1'b0;
   int nxt = 0;
   int done_cnt = 0;
   bit hold_p = 1'b0;
   logic [2:0]  hold_a;
   logic [31:0] hold_d;

   function automatic longint key(input int k, input longint idx);
      return longint'(k) * 64'd1000000 + idx;
   endfunction

   function automatic logic [31:0] bmask(input logic [3:0] m);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = {8{m[i]}};
      return r;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: byte-addressed store with known-byte tracking, plus dump scoreboard
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < 3; k++) begin
            exp_rd[k] = 32'h0; exp_m[k] = 4'hF; exp_rv[k] = 1'b0; exp_oor[k] = 1'b0;
         end
         nxt = 0;
         hold_p = 1'b0;
      end else begin
`ifdef DMEM_DUMP_EN
         if (hold_p) begin
            chk("dump_hold", {dv_c, da_c, dd_c}, {1'b1, hold_a, hold_d});
            hold_p = 1'b0;
         end
         if (dv_c && dr_c) begin
            chk("dump_addr_seq", 64'(da_c), 64'(nxt));
            chk("dump_data", dd_c, mdat.exists(key(2, longint'(da_c))) ?
                mdat[key(2, longint'(da_c))] : 32'hFFFF_FFFF);
            nxt++;
         end else if (dv_c) begin
            hold_p = 1'b1; hold_a = da_c; hold_d = dd_c;
         end
         if (dn_c) begin
            chk("dump_done_after_last", 64'(nxt), 64'd8);
            done_cnt++;
            nxt = 0;
         end
`endif
         for (int k = 0; k < 3; k++) begin
            longint a, idx, kk;
            bit inr;
            logic [31:0] w, r;
            logic [3:0] kn, m;
            a   = longint'(address);
            idx = a - base_k[k];
            inr = (a >= base_k[k]) && (idx < depth_k[k]);
            kk  = key(k, idx);
            w   = mdat.exists(kk) ? mdat[kk] : 32'h0;
            kn  = mkn.exists(kk) ? mkn[kk] : 4'h0;
            exp_oor[k] = (we || re) && !inr;
            exp_rv[k]  = re;
            if (re) begin
               if (inr) begin
                  r = 32'h0; m = 4'h0;
                  for (int i = 0; i < 4; i++) begin
                     if (we && be[i]) begin
                        r[8*i +: 8] = wd[8*i +: 8]; m[i] = 1'b1;
                     end else begin
                        r[8*i +: 8] = w[8*i +: 8]; m[i] = kn[i];
                     end
                  end
                  exp_rd[k] = r; exp_m[k] = m;
               end else begin
                  exp_rd[k] = 32'h0; exp_m[k] = 4'hF;
               end
            end
            if (we && inr) begin
               for (int i = 0; i < 4; i++) begin
                  if (be[i]) begin
                     w[8*i +: 8] = wd[8*i +: 8]; kn[i] = 1'b1;
                  end
               end
               mdat[kk] = w; mkn[kk] = kn;
            end
         end
      end
   end

   // Per-cycle comparison of the CPU ports of every instance against the model
   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < 3; k++) begin
            chk($sformatf("rd[%0d]", k), act_rd[k] & bmask(exp_m[k]), exp_rd[k] & bmask(exp_m[k]));
            chk($sformatf("rd_valid[%0d]", k), act_rv[k], exp_rv[k]);
            chk($sformatf("oor[%0d]", k), act_oor[k], exp_oor[k]);
         end
`ifndef DMEM_DUMP_EN
         chk("dump_tied_off", {dv_c, db_c, dn_c, da_c, dd_c}, 64'h0);
`endif
      end
   end

   task automatic op(input logic w, input logic r, input logic [31:0] a,
                     input logic [3:0] b, input logic [31:0] d);
      @(negedge clk);
      we = w; re = r; address = a; be = b; wd = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit hit;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk_en = 1'b1;
      @(posedge clk); #1;
      chk("reset_rd", rd_a, 32'h0);
      chk("reset_rd_valid", rv_a, 1'b0);
      chk("reset_oor", oor_a, 1'b0);
      chk("reset_dump", {dv_c, db_c, dn_c, da_c, dd_c}, 64'h0);

      op(1, 0, 32'd5, 4'hF, 32'hDEADBEEF);
      op(0, 1, 32'd5, 4'h0, 32'h0);
      chk("rd_deadbeef", rd_a, 32'hDEADBEEF);
      chk("rd_valid_pulse", rv_a, 1'b1);
      op(0, 0, 32'd0, 4'h0, 32'h0);
      chk("rd_valid_drop", rv_a, 1'b0);
      chk("rd_hold", rd_a, 32'hDEADBEEF);

      op(1, 1, 32'd5, 4'b0101, 32'h11223344);
      chk("rd_write_first", rd_a, 32'hDE22BE44);

      op(1, 0, 32'd129600, 4'hF, 32'h0BADF00D);
      chk("oor_write", oor_a, 1'b1);
      chk("oor_write_no_valid", rv_a, 1'b0);
      op(0, 1, 32'd129600, 4'h0, 32'h0);
      chk("oor_read_rd", rd_a, 32'h0);
      chk("oor_read_valid", rv_a, 1'b1);
      chk("oor_read_flag", oor_a, 1'b1);
      op(0, 1, 32'd5, 4'h0, 32'h0);
      chk("mem_unchanged", rd_a, 32'hDE22BE44);
      chk("oor_clear", oor_a, 1'b0);

      op(0, 1, 32'd999, 4'h0, 32'h0);
      chk("base_below", oor_b, 1'b1);
      op(1, 0, 32'd1015, 4'hF, 32'hCAFE0001);
      chk("base_top_write", oor_b, 1'b0);
      op(0, 1, 32'd1015, 4'h0, 32'h0);
      chk("base_top_read", rd_b, 32'hCAFE0001);
      chk("base_top_oor", oor_b, 1'b0);
      op(0, 1, 32'd1016, 4'h0, 32'h0);
      chk("base_past_end", oor_b, 1'b1);
      chk("base_past_end_rd", rd_b, 32'h0);

      for (int i = 0; i < 8; i++) op(1, 0, 32'(i), 4'hF, 32'(i));
      op(0, 0, 32'd0, 4'h0, 32'h0);

`ifdef DMEM_DUMP_EN
      @(negedge clk); ds_c = 1'b1; dr_c = 1'b0;
      @(negedge clk); ds_c = 1'b0;
      for (int c = 0; c < 100 && done_cnt < 1; c++) begin
         @(negedge clk);
         dr_c = ~dr_c;
         ds_c = (c == 4);
      end
      ds_c = 1'b0;
      repeat (4) @(negedge clk);
      chk("dump_done_once", 64'(done_cnt), 64'd1);

      @(negedge clk); ds_c = 1'b1; dr_c = 1'b1;
      @(negedge clk); ds_c = 1'b0;
      hit = 1'b0;
      for (int c = 0; c < 100 && !hit; c++) begin
         @(negedge clk);
         if (dv_c && da_c == 3'd3) begin
            dr_c = 1'b0;
            hit = 1'b1;
         end
      end
      chk("reach_ptr3", hit, 1'b1);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("rst_dump_valid", dv_c, 1'b0);
      chk("rst_dump_busy", db_c, 1'b0);
      chk("rst_dump_addr", da_c, 3'd0);
      chk("rst_dump_data", dd_c, 32'h0);
      @(negedge clk); reset = 1'b0;
      repeat (4) @(negedge clk);
      chk("no_done_on_reset", 64'(done_cnt), 64'd1);

      @(negedge clk); ds_c = 1'b1; dr_c = 1'b1;
      @(negedge clk); ds_c = 1'b0;
      hit = 1'b0;
      for (int c = 0; c < 20 && !hit; c++) begin
         if (dv_c) hit = 1'b1;
         else @(negedge clk);
      end
      chk("restart_valid", hit, 1'b1);
      chk("restart_addr0", da_c, 3'd0);
      for (int c = 0; c < 100 && done_cnt < 2; c++) @(negedge clk);
      chk("dump_done_twice", 64'(done_cnt), 64'd2);
`else
      @(negedge clk); ds_c = 1'b1; dr_c = 1'b1;
      repeat (6) @(negedge clk);
      ds_c = 1'b0;
      #1;
      chk("dump_off_valid", dv_c, 1'b0);
      chk("dump_off_busy", db_c, 1'b0);
`endif

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
